// File: rtl/dbus_sram_responder_pkg.sv
// Shared dbus types and helpers: responder FSM states, access-size codes and
// the natural-alignment check applied to every request.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dbus_rsp_state_t;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // Illegal size codes are reported as misaligned so they fault as well.
  function automatic logic size_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
    case (size)
      MSIZE1:  size_aligned = 1'b1;
      MSIZE2:  size_aligned = (addr_lo[0] == 1'b0);
      MSIZE4:  size_aligned = (addr_lo[1:0] == 2'b00);
      MSIZE8:  size_aligned = (addr_lo == 3'b000);
      default: size_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_sram_bank.sv
// Single-port 64-bit word SRAM with per-byte write enables.
// Write lands on the clock edge; read is combinational from idx.
module dbus_sram_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [7:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus responder serving one request at a time from local SRAM: addr_ok in the
// accept cycle, data_ok LATENCY+1 cycles later; the initiator holds req_valid.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic [31:0] err_count
);

  dbus_rsp_state_t       state;
  dbus_req_t             req_in;
  dbus_req_t             req_q;
  logic                  fault_in;
  logic                  fault_q;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [63:0]           rdata;
  logic                  we;

  // Range test on the offset so a window ending at the top of the address
  // space cannot overflow.
  function automatic logic is_fault(input dbus_req_t r);
    logic [63:0] offs;
    logic        in_range;
    offs     = r.addr - BASE_ADDR;
    in_range = (r.addr >= BASE_ADDR) && (offs < (64'd8 << DEPTH_LOG2));
    is_fault = !in_range || (r.size > MSIZE8) || !size_aligned(r.addr[2:0], r.size);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign req_in   = '{addr: req_addr, size: req_size, strobe: req_strobe, data: req_data};
  assign fault_in = is_fault(req_in);

  assign resp_addr_ok = (state == IDLE) && req_valid && !rst;
  assign idx          = DEPTH_LOG2'((req_q.addr - BASE_ADDR) >> 3);
  assign we           = (state == RESP) && (|req_q.strobe) && !fault_q;
  assign resp_data    = (resp_data_ok && !fault_q) ? rdata : 64'd0;

  dbus_sram_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
    .clk   (clk),
    .we    (we),
    .be    (req_q.strobe),
    .idx   (idx),
    .wdata (req_q.data),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      resp_data_ok <= 1'b0;
      err_count    <= 32'd0;
      cnt          <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q   <= req_in;
            fault_q <= fault_in;
            if (LATENCY == 0) begin
              state        <= RESP;
              resp_data_ok <= 1'b1;
              if (fault_in) err_count <= sat_inc(err_count);
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state        <= RESP;
            resp_data_ok <= 1'b1;
            if (fault_q) err_count <= sat_inc(err_count);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state        <= IDLE;
          resp_data_ok <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          resp_data_ok <= 1'b0;
        end
      endcase
    end
  end

endmodule
